rf_banked: RTL and testbench
============================

Name: rf_banked

Overview:
- Parametrised successor to the team's 8-bit register file.
- Provides a register array of configurable width and depth, two independently addressed registered read ports and one write port with same-cycle write-to-read bypass.
- Holds a masked-update flags register, duplicated across two banks (active and shadow) that are exchanged by a single swap pulse for fast interrupt context switches.
- Sits between the core datapath and the ALU flag logic.

Parameters:
- WIDTH, 8, data width of every register.
- DEPTH, 4, registers per bank; power of two, >= 2. Address width AW = $clog2(DEPTH) (localparam).
- FW, 4, flags register width.
- ZERO_R0, 0, when 1 register 0 of each bank reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- d  in  WIDTH  write data.
- wa  in  AW  write address.
- we  in  1  write enable.
- ra0  in  AW  read address, port 0.
- ra1  in  AW  read address, port 1.
- re  in  1  read enable, both ports.
- fd  in  FW  flag write data.
- fm  in  FW  flag write mask, 1 = bit updated.
- fe  in  1  flag write enable.
- swp  in  1  bank swap request, single-cycle pulse.
- q0  out  WIDTH  registered read data, port 0.
- q1  out  WIDTH  registered read data, port 1.
- fo  out  FW  flags of the active bank.
- fod  out  FW  fo delayed one clock.
- bsel  out  1  active bank index.

Behaviour:
Reset (rst=0, asynchronous):
- Both banks' registers and flags, q0, q1, fod cleared to 0; bsel=0.
- Reset asserted mid-operation discards any in-flight write or swap.
- Release is sampled synchronously: first update on the first rising clk edge with rst=1.

Write:
- On the rising edge with we=1, reg[bsel][wa] <= d.
- With ZERO_R0=1 and wa=0 the write is ignored.

Read (1-cycle latency):
- On the rising edge with re=1, q0 <= reg[bsel][ra0] and q1 <= reg[bsel][ra1].
- With re=0, q0/q1 hold their previous values.

Bypass:
- If re=1, we=1 and ra0==wa in the same cycle, q0 <= d (new data). Same rule for port 1 independently.
- No bypass when ZERO_R0=1 and the address is 0; q gets 0.
- Both ports may read the same address; both return the same value.

Flags:
- On fe=1: flags[bsel] <= (flags[bsel] & ~fm) | (fd & fm).
- fe=1 with fm=0 leaves flags unchanged.
- fo = flags[bsel] (combinational from state). fod <= fo every clock.

Swap:
- On the rising edge with swp=1, bsel <= ~bsel.
- All other operations in the same cycle (write, read, bypass, flag write) use the old bsel.
- fo reflects the new bank from the following cycle.
- swp held high toggles the bank every cycle.
- The shadow bank's contents are retained untouched while inactive.

General rules:
- All arithmetic is width-exact; addresses wrap naturally within AW bits. No out-of-range case exists since DEPTH is a power of two.
- No handshake and no stall: every request completes in its issue cycle.

Test Plan:
- Reset: drive rst=0 at a non-edge time mid-simulation -> q0, q1, fo, fod, bsel read 0 immediately; after release, reading reg 2 returns 0.
- Write/read latency: we=1 wa=1 d=8'hA5, next cycle re=1 ra0=1 -> q0=8'hA5 one edge later; with re=0 q0 holds 8'hA5 while d changes.
- Bypass: re=1 we=1 wa=3 ra0=3 ra1=2 d=8'h3C, reg2 previously 8'h11 -> after the edge q0=8'h3C, q1=8'h11; with ZERO_R0=1 and wa=ra0=0 -> q0=0.
- Masked flags: flags=4'b1010, fe=1 fd=4'b0101 fm=4'b0011 -> fo=4'b1001 after the edge, fod=4'b1001 one edge later.
- Swap isolation: bank0 reg1=8'h55; swp=1 with we=1 wa=1 d=8'h77 in the same cycle -> bank0 reg1=8'h77, bsel=1, read reg1 gives 0; write 8'hEE; swp again -> read reg1 gives 8'h77.
- Reset mid-swap: assert rst=0 in the same cycle as swp=1 -> bsel=0 and all state 0 after release.

Source files
------------

// File: rtl/rf_banked.sv
// rf_banked: banked register file with two registered read ports, one write
// port with write-to-read bypass, and a masked flags register. Two banks
// (active/shadow) are exchanged by a single swap pulse.
module rf_banked #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int FW      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic [$clog2(DEPTH)-1:0]   wa,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   ra0,
  input  logic [$clog2(DEPTH)-1:0]   ra1,
  input  logic                       re,
  input  logic [FW-1:0]              fd,
  input  logic [FW-1:0]              fm,
  input  logic                       fe,
  input  logic                       swp,
  output logic [WIDTH-1:0]           q0,
  output logic [WIDTH-1:0]           q1,
  output logic [FW-1:0]              fo,
  output logic [FW-1:0]              fod,
  output logic                       bsel
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem   [2][DEPTH];
  logic [FW-1:0]    flags [2];

  logic             wr_ok;
  logic [WIDTH-1:0] nq0;
  logic [WIDTH-1:0] nq1;

  // Read-data selection: array contents, overridden by same-cycle write
  // data, overridden again by the hard-wired zero register when enabled.
  always_comb begin
    wr_ok = we && !((ZERO_R0 != 0) && (wa == '0));
    nq0   = mem[bsel][ra0];
    nq1   = mem[bsel][ra1];
    if (we && (ra0 == wa)) nq0 = d;
    if (we && (ra1 == wa)) nq1 = d;
    if ((ZERO_R0 != 0) && (ra0 == '0)) nq0 = '0;
    if ((ZERO_R0 != 0) && (ra1 == '0)) nq1 = '0;
  end

  // Active bank flags are visible combinationally.
  assign fo = flags[bsel];

  // Register array write into the currently active bank (pre-swap bsel).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++)
          mem[b][i] <= '0;
    end else if (wr_ok) begin
      mem[bsel][wa] <= d;
    end
  end

  // Registered read ports; hold their value while re is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0 <= '0;
      q1 <= '0;
    end else if (re) begin
      q0 <= nq0;
      q1 <= nq1;
    end
  end

  // Masked flag update on the active bank, one-cycle delayed copy, and bank swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags[0] <= '0;
      flags[1] <= '0;
      fod      <= '0;
      bsel     <= 1'b0;
    end else begin
      if (fe) flags[bsel] <= (flags[bsel] & ~fm) | (fd & fm);
      fod  <= fo;
      bsel <= bsel ^ swp;
    end
  end

  // AW is derived for readability of the address ports' intent.
  logic [AW-1:0] unused_aw;
  assign unused_aw = wa ^ wa;

endmodule

// File: tb/tb_rf_banked.sv
// Directed testbench for rf_banked: a default instance and a ZERO_R0=1
// instance share all stimulus.
module tb_rf_banked;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic [1:0] wa, ra0, ra1;
  logic       we, re, fe, swp;
  logic [3:0] fd, fm;
  logic [7:0] q0, q1, zq0, zq1;
  logic [3:0] fo, fod, zfo, zfod;
  logic       bsel, zbsel;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rf_banked #(.WIDTH(8), .DEPTH(4), .FW(4), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .d(d), .wa(wa), .we(we), .ra0(ra0), .ra1(ra1),
    .re(re), .fd(fd), .fm(fm), .fe(fe), .swp(swp),
    .q0(q0), .q1(q1), .fo(fo), .fod(fod), .bsel(bsel)
  );

  rf_banked #(.WIDTH(8), .DEPTH(4), .FW(4), .ZERO_R0(1)) dutz (
    .clk(clk), .rst(rst), .d(d), .wa(wa), .we(we), .ra0(ra0), .ra1(ra1),
    .re(re), .fd(fd), .fm(fm), .fe(fe), .swp(swp),
    .q0(zq0), .q1(zq1), .fo(zfo), .fod(zfod), .bsel(zbsel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re = 0; fe = 0; swp = 0;
  endtask

  task automatic test_reset();
    rst = 1; d = 0; wa = 0; ra0 = 0; ra1 = 0; fd = 0; fm = 0;
    idle();
    #1 rst = 0;
    #2;
    total_cnt++; if (q0 !== 8'h00) $display("FAIL reset_q0 got %h want 00", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'h00) $display("FAIL reset_q1 got %h want 00", q1); else pass_cnt++;
    total_cnt++; if (fo !== 4'h0) $display("FAIL reset_fo got %h want 0", fo); else pass_cnt++;
    total_cnt++; if (fod !== 4'h0) $display("FAIL reset_fod got %h want 0", fod); else pass_cnt++;
    total_cnt++; if (bsel !== 1'b0) $display("FAIL reset_bsel got %b want 0", bsel); else pass_cnt++;
    #9 rst = 1;
    step();
  endtask

  task automatic test_write_read();
    we = 1; wa = 1; d = 8'hA5;
    step();
    we = 0; re = 1; ra0 = 1; ra1 = 0;
    step();
    total_cnt++; if (q0 !== 8'hA5) $display("FAIL wr_rd_q0 got %h want a5", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'h00) $display("FAIL wr_rd_q1 got %h want 00", q1); else pass_cnt++;
    re = 0; ra0 = 2; we = 1; wa = 2; d = 8'h11;
    step();
    total_cnt++; if (q0 !== 8'hA5) $display("FAIL hold_q0 got %h want a5", q0); else pass_cnt++;
    idle();
  endtask

  task automatic test_bypass();
    re = 1; we = 1; wa = 3; ra0 = 3; ra1 = 2; d = 8'h3C;
    step();
    total_cnt++; if (q0 !== 8'h3C) $display("FAIL bypass_q0 got %h want 3c", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'h11) $display("FAIL bypass_q1 got %h want 11", q1); else pass_cnt++;
    we = 1; wa = 2; d = 8'h22; ra0 = 3; ra1 = 2;
    step();
    total_cnt++; if (q0 !== 8'h3C) $display("FAIL bypass1_q0 got %h want 3c", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'h22) $display("FAIL bypass1_q1 got %h want 22", q1); else pass_cnt++;
    we = 0; ra0 = 1; ra1 = 1;
    step();
    total_cnt++; if (q0 !== 8'hA5) $display("FAIL same_addr_q0 got %h want a5", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'hA5) $display("FAIL same_addr_q1 got %h want a5", q1); else pass_cnt++;
    we = 1; wa = 0; ra0 = 0; ra1 = 1; d = 8'h99;
    step();
    total_cnt++; if (q0 !== 8'h99) $display("FAIL r0_bypass got %h want 99", q0); else pass_cnt++;
    total_cnt++; if (zq0 !== 8'h00) $display("FAIL zr0_bypass got %h want 00", zq0); else pass_cnt++;
    total_cnt++; if (zq1 !== 8'hA5) $display("FAIL zr0_q1 got %h want a5", zq1); else pass_cnt++;
    we = 0;
    step();
    total_cnt++; if (q0 !== 8'h99) $display("FAIL r0_stored got %h want 99", q0); else pass_cnt++;
    total_cnt++; if (zq0 !== 8'h00) $display("FAIL zr0_stored got %h want 00", zq0); else pass_cnt++;
    idle();
  endtask

  task automatic test_flags();
    fe = 1; fd = 4'b1010; fm = 4'b1111;
    step();
    total_cnt++; if (fo !== 4'b1010) $display("FAIL flag_load got %b want 1010", fo); else pass_cnt++;
    fd = 4'b0101; fm = 4'b0011;
    step();
    total_cnt++; if (fo !== 4'b1001) $display("FAIL flag_mask got %b want 1001", fo); else pass_cnt++;
    total_cnt++; if (fod !== 4'b1010) $display("FAIL fod_prev got %b want 1010", fod); else pass_cnt++;
    fd = 4'b1111; fm = 4'b0000;
    step();
    total_cnt++; if (fo !== 4'b1001) $display("FAIL flag_nomask got %b want 1001", fo); else pass_cnt++;
    total_cnt++; if (fod !== 4'b1001) $display("FAIL fod_delay got %b want 1001", fod); else pass_cnt++;
    idle();
  endtask

  task automatic test_swap();
    we = 1; wa = 1; d = 8'h55;
    step();
    swp = 1; we = 1; wa = 1; d = 8'h77; re = 1; ra0 = 1; ra1 = 1;
    step();
    total_cnt++; if (bsel !== 1'b1) $display("FAIL swap_bsel got %b want 1", bsel); else pass_cnt++;
    total_cnt++; if (q0 !== 8'h77) $display("FAIL swap_oldbank_read got %h want 77", q0); else pass_cnt++;
    total_cnt++; if (fo !== 4'b0000) $display("FAIL swap_fo_bank1 got %b want 0000", fo); else pass_cnt++;
    swp = 0; we = 0; re = 1; ra0 = 1;
    step();
    total_cnt++; if (q0 !== 8'h00) $display("FAIL bank1_reg1 got %h want 00", q0); else pass_cnt++;
    re = 0; we = 1; wa = 1; d = 8'hEE;
    step();
    we = 0; swp = 1;
    step();
    total_cnt++; if (bsel !== 1'b0) $display("FAIL swap_back_bsel got %b want 0", bsel); else pass_cnt++;
    total_cnt++; if (fo !== 4'b1001) $display("FAIL bank0_flags_kept got %b want 1001", fo); else pass_cnt++;
    swp = 0; re = 1; ra0 = 1;
    step();
    total_cnt++; if (q0 !== 8'h77) $display("FAIL bank0_reg1_kept got %h want 77", q0); else pass_cnt++;
    re = 0; swp = 1;
    step();
    swp = 0; re = 1; ra0 = 1;
    step();
    total_cnt++; if (q0 !== 8'hEE) $display("FAIL bank1_reg1_kept got %h want ee", q0); else pass_cnt++;
    re = 0; swp = 1;
    step();
    total_cnt++; if (bsel !== 1'b0) $display("FAIL hold_swp0 got %b want 0", bsel); else pass_cnt++;
    step();
    total_cnt++; if (bsel !== 1'b1) $display("FAIL hold_swp1 got %b want 1", bsel); else pass_cnt++;
    step();
    total_cnt++; if (bsel !== 1'b0) $display("FAIL hold_swp2 got %b want 0", bsel); else pass_cnt++;
    idle();
    re = 1; ra0 = 1;
    step();
    re = 0;
  endtask

  task automatic test_async_reset();
    swp = 1; we = 1; wa = 2; d = 8'hAB; fe = 1; fd = 4'hF; fm = 4'hF;
    #2 rst = 0;
    #1;
    total_cnt++; if (q0 !== 8'h00) $display("FAIL arst_q0 got %h want 00", q0); else pass_cnt++;
    total_cnt++; if (fo !== 4'h0) $display("FAIL arst_fo got %h want 0", fo); else pass_cnt++;
    total_cnt++; if (fod !== 4'h0) $display("FAIL arst_fod got %h want 0", fod); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (bsel !== 1'b0) $display("FAIL arst_swap_bsel got %b want 0", bsel); else pass_cnt++;
    #2;
    idle();
    rst = 1;
    re = 1; ra0 = 2; ra1 = 1;
    step();
    total_cnt++; if (q0 !== 8'h00) $display("FAIL post_rst_reg2 got %h want 00", q0); else pass_cnt++;
    total_cnt++; if (q1 !== 8'h00) $display("FAIL post_rst_reg1 got %h want 00", q1); else pass_cnt++;
    total_cnt++; if (bsel !== 1'b0) $display("FAIL post_rst_bsel got %b want 0", bsel); else pass_cnt++;
    total_cnt++; if (fo !== 4'h0) $display("FAIL post_rst_fo got %h want 0", fo); else pass_cnt++;
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_flags();
    test_swap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
